// File: rtl/draw_scheduler.sv
// Shares one rectangle-draw engine among NUM_REQ requesters: arbitrate, latch, load, draw, acknowledge.
// Optional ROUND_ROBIN_EN selects round-robin arbitration; the default is fixed lowest-index priority.
module draw_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1100
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_x,
    input  logic [7*NUM_REQ-1:0] req_y,
    input  logic [5*NUM_REQ-1:0] req_w,
    input  logic [5*NUM_REQ-1:0] req_h,
    input  logic [3*NUM_REQ-1:0] req_c,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 err,
    output logic                 busy,
    output logic [7:0]           eng_x,
    output logic [6:0]           eng_y,
    output logic [4:0]           eng_w,
    output logic [4:0]           eng_h,
    output logic [2:0]           eng_c,
    output logic                 eng_enable,
    output logic                 eng_reset_n,
    input  logic                 eng_done,
    output logic                 plot
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_ACK} state_t;

    state_t             state_q;
    logic [IW-1:0]      grant_q;
    logic [CW-1:0]      cnt_q;
    logic [NUM_REQ-1:0] ack_q;
    logic               err_q, busy_q, enable_q, plot_q, eng_rst_n_q;
    logic [7:0]         eng_x_q;
    logic [6:0]         eng_y_q;
    logic [4:0]         eng_w_q, eng_h_q;
    logic [2:0]         eng_c_q;
`ifdef ROUND_ROBIN_EN
    logic [IW-1:0]      rr_q;
`endif

    logic               any_req_d;
    logic [IW-1:0]      grant_d;
    logic [7:0]         sel_x_d;
    logic [6:0]         sel_y_d;
    logic [4:0]         sel_w_d, sel_h_d;
    logic [2:0]         sel_c_d;

    // Search order starts at the rr pointer (round robin) or at index 0 (fixed priority).
    always_comb begin
        int idx;
        idx       = 0;
        any_req_d = 1'b0;
        grant_d   = '0;
        sel_x_d   = '0;
        sel_y_d   = '0;
        sel_w_d   = '0;
        sel_h_d   = '0;
        sel_c_d   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef ROUND_ROBIN_EN
            idx = (int'(rr_q) + i) % NUM_REQ;
`else
            idx = i;
`endif
            if (!any_req_d && req[idx]) begin
                any_req_d = 1'b1;
                grant_d   = IW'(idx);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_d == IW'(i)) begin
                sel_x_d = req_x[8*i +: 8];
                sel_y_d = req_y[7*i +: 7];
                sel_w_d = req_w[5*i +: 5];
                sel_h_d = req_h[5*i +: 5];
                sel_c_d = req_c[3*i +: 3];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            cnt_q       <= '0;
            ack_q       <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            enable_q    <= 1'b0;
            plot_q      <= 1'b0;
            eng_rst_n_q <= 1'b0;
            eng_x_q     <= '0;
            eng_y_q     <= '0;
            eng_w_q     <= '0;
            eng_h_q     <= '0;
            eng_c_q     <= '0;
`ifdef ROUND_ROBIN_EN
            rr_q        <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_req_d) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                        grant_q <= grant_d;
                        eng_x_q <= sel_x_d;
                        eng_y_q <= sel_y_d;
                        eng_w_q <= sel_w_d;
                        eng_h_q <= sel_h_d;
                        eng_c_q <= sel_c_d;
                    end
                end
                S_LOAD: begin
                    state_q     <= S_DRAW;
                    eng_rst_n_q <= 1'b1;
                    enable_q    <= 1'b1;
                    plot_q      <= 1'b1;
                end
                S_DRAW: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (eng_done || cnt_q == CW'(TIMEOUT - 1)) begin
                        state_q     <= S_ACK;
                        eng_rst_n_q <= 1'b0;
                        enable_q    <= 1'b0;
                        plot_q      <= 1'b0;
                        ack_q       <= ONE_HOT0 << grant_q;
                        err_q       <= ~eng_done;
                    end
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                    ack_q   <= '0;
                    err_q   <= 1'b0;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
`ifdef ROUND_ROBIN_EN
                    rr_q    <= (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // NOTE: done gates enable/plot combinationally so the engine stops in the very cycle it finishes;
    // the registered copies only drop at the following edge.
    assign eng_enable  = enable_q & ~eng_done;
    assign plot        = plot_q & ~eng_done;
    assign eng_reset_n = eng_rst_n_q;
    assign ack         = ack_q;
    assign err         = err_q;
    assign busy        = busy_q;
    assign eng_x       = eng_x_q;
    assign eng_y       = eng_y_q;
    assign eng_w       = eng_w_q;
    assign eng_h       = eng_h_q;
    assign eng_c       = eng_c_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Scoreboard bench for draw_scheduler: directed requests, a simple engine model and an ack monitor.
module tb_draw_scheduler;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 1100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_x;
    logic [7*NUM_REQ-1:0] req_y;
    logic [5*NUM_REQ-1:0] req_w;
    logic [5*NUM_REQ-1:0] req_h;
    logic [3*NUM_REQ-1:0] req_c;
    logic [NUM_REQ-1:0]   ack;
    logic                 err, busy, eng_enable, eng_reset_n, eng_done, plot;
    logic [7:0]           eng_x;
    logic [6:0]           eng_y;
    logic [4:0]           eng_w, eng_h;
    logic [2:0]           eng_c;

    draw_scheduler #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req),
        .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h), .req_c(req_c),
        .ack(ack), .err(err), .busy(busy),
        .eng_x(eng_x), .eng_y(eng_y), .eng_w(eng_w), .eng_h(eng_h), .eng_c(eng_c),
        .eng_enable(eng_enable), .eng_reset_n(eng_reset_n), .eng_done(eng_done),
        .plot(plot)
    );

    typedef struct {
        logic [NUM_REQ-1:0] ack;
        logic               err;
        logic [7:0]         x;
        logic [6:0]         y;
        logic [4:0]         w;
        logic [4:0]         h;
        logic [2:0]         c;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    // Engine model: finishes after w*h enabled cycles unless told to hang.
    bit   hang = 1'b0;
    int   eng_cnt = 0;
    logic eng_done_r = 1'b0;
    assign eng_done = eng_done_r;

    always @(posedge clk) begin
        if (!eng_reset_n) begin
            eng_cnt    <= 0;
            eng_done_r <= 1'b0;
        end else if (eng_enable && !eng_done_r) begin
            eng_cnt <= eng_cnt + 1;
            if (!hang && (eng_cnt + 1 == int'(eng_w) * int'(eng_h)))
                eng_done_r <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_fields(input int i, input logic [7:0] x, input logic [6:0] y,
                              input logic [4:0] w, input logic [4:0] h, input logic [2:0] c);
        req_x[8*i +: 8] = x;
        req_y[7*i +: 7] = y;
        req_w[5*i +: 5] = w;
        req_h[5*i +: 5] = h;
        req_c[3*i +: 3] = c;
    endtask

    task automatic push(input int i, input logic e);
        exp_t t;
        t.ack = NUM_REQ'(1) << i;
        t.err = e;
        t.x   = req_x[8*i +: 8];
        t.y   = req_y[7*i +: 7];
        t.w   = req_w[5*i +: 5];
        t.h   = req_h[5*i +: 5];
        t.c   = req_c[3*i +: 3];
        sb.push_back(t);
    endtask

    // Advance negedges until ack appears or budget expires; counts plot-high cycles on the way.
    task automatic run_to_ack(input int budget, output int plot_cycles);
        plot_cycles = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (ack != '0) return;
            if (plot) plot_cycles++;
        end
    endtask

    task automatic wait_plot(input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (plot) return;
        end
    endtask

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && ack != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_ack",   32'(ack),   32'(mon_e.ack));
                check("sb_err",   32'(err),   32'(mon_e.err));
                check("sb_eng_x", 32'(eng_x), 32'(mon_e.x));
                check("sb_eng_y", 32'(eng_y), 32'(mon_e.y));
                check("sb_eng_w", 32'(eng_w), 32'(mon_e.w));
                check("sb_eng_h", 32'(eng_h), 32'(mon_e.h));
                check("sb_eng_c", 32'(eng_c), 32'(mon_e.c));
            end
        end
        if (reset === 1'b1 && err && ack == '0)
            check("err_without_ack", 32'(err), 32'd0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int pc;
    int order[5];

    initial begin
        reset = 1'b0;
        req   = '0;
        req_x = '0;
        req_y = '0;
        req_w = '0;
        req_h = '0;
        req_c = '0;
        repeat (3) @(negedge clk);
        check("rst_ack",   32'(ack), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_plot",  32'(plot), 32'd0);
        check("rst_en",    32'(eng_enable), 32'd0);
        check("rst_eng_rn", 32'(eng_reset_n), 32'd0);
        check("rst_eng_x", 32'(eng_x), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single request on requester 0.
        set_fields(0, 8'd10, 7'd20, 5'd3, 5'd2, 3'b100);
        push(0, 1'b0);
        req = 4'b0001;
        @(negedge clk);
        check("t1_load_busy", 32'(busy), 32'd1);
        check("t1_load_rn",   32'(eng_reset_n), 32'd0);
        check("t1_load_plot", 32'(plot), 32'd0);
        check("t1_load_x",    32'(eng_x), 32'd10);
        check("t1_load_y",    32'(eng_y), 32'd20);
        @(negedge clk);
        check("t1_draw_rn",   32'(eng_reset_n), 32'd1);
        check("t1_draw_en",   32'(eng_enable), 32'd1);
        run_to_ack(200, pc);
        check("t1_ack_seen",  32'(ack != '0), 32'd1);
        check("t1_plot_cycles", 32'(pc + 1), 32'd6);
        check("t1_ack_plot",  32'(plot), 32'd0);
        req = '0;
        @(negedge clk);
        check("t1_ack_1cyc",  32'(ack), 32'd0);
        check("t1_idle_busy", 32'(busy), 32'd0);

        // Two requesters held continuously.
        set_fields(1, 8'd33, 7'd44, 5'd2, 5'd2, 3'b010);
        set_fields(3, 8'd77, 7'd88, 5'd3, 5'd1, 3'b001);
`ifdef ROUND_ROBIN_EN
        push(1, 1'b0); push(3, 1'b0); push(1, 1'b0);
`else
        push(1, 1'b0); push(1, 1'b0); push(1, 1'b0);
`endif
        req = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            run_to_ack(200, pc);
            check("t2_ack_seen", 32'(ack != '0), 32'd1);
        end
        req = '0;

        // Requester 2 drops req and changes x mid-draw.
        @(negedge clk);
        set_fields(2, 8'd50, 7'd60, 5'd4, 5'd4, 3'b101);
        push(2, 1'b0);
        req = 4'b0100;
        wait_plot(20);
        check("t5_plot_seen", 32'(plot), 32'd1);
        req_x[8*2 +: 8] = 8'd99;
        req = '0;
        @(negedge clk);
        check("t5_x_stable", 32'(eng_x), 32'd50);
        run_to_ack(200, pc);
        check("t5_ack_seen", 32'(ack != '0), 32'd1);

        // Engine never finishes: timeout.
        @(negedge clk);
        hang = 1'b1;
        set_fields(3, 8'd1, 7'd2, 5'd1, 5'd1, 3'b111);
        push(3, 1'b1);
        req = 4'b1000;
        @(negedge clk);
        run_to_ack(TIMEOUT + 50, pc);
        check("t3_ack_seen", 32'(ack != '0), 32'd1);
        check("t3_draw_cycles", 32'(pc), 32'(TIMEOUT));
        check("t3_err", 32'(err), 32'd1);
        req  = '0;
        hang = 1'b0;
        @(negedge clk);
        check("t3_idle_busy", 32'(busy), 32'd0);
        check("t3_err_clear", 32'(err), 32'd0);

        // Reset in the middle of a draw: no ack for the aborted request.
        set_fields(1, 8'd100, 7'd30, 5'd8, 5'd8, 3'b010);
        req = 4'b0010;
        wait_plot(20);
        check("t4_plot_seen", 32'(plot), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        req   = '0;
        @(negedge clk);
        check("t4_ack",  32'(ack), 32'd0);
        check("t4_err",  32'(err), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_en",   32'(eng_enable), 32'd0);
        check("t4_plot", 32'(plot), 32'd0);
        check("t4_rn",   32'(eng_reset_n), 32'd0);
        check("t4_data", 32'({eng_x, eng_y, eng_w, eng_h, eng_c}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("t4_no_ack", 32'(ack), 32'd0);

        // All four requesters held.
        set_fields(0, 8'd11, 7'd1, 5'd1, 5'd2, 3'b001);
        set_fields(1, 8'd22, 7'd2, 5'd2, 5'd1, 3'b010);
        set_fields(2, 8'd33, 7'd3, 5'd1, 5'd3, 3'b011);
        set_fields(3, 8'd44, 7'd4, 5'd2, 5'd2, 3'b100);
`ifdef ROUND_ROBIN_EN
        order = '{0, 1, 2, 3, 0};
`else
        order = '{0, 0, 0, 0, 0};
`endif
        foreach (order[k]) push(order[k], 1'b0);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            run_to_ack(200, pc);
            check("t6_ack_seen", 32'(ack != '0), 32'd1);
        end
        req = '0;

        repeat (6) @(negedge clk);
        check("end_sb_drained", 32'(sb.size()), 32'd0);
        check("end_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
